// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmit FSM states and default word size.
// The receive-side checker imports the same parity constants.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] PARITY_NONE0 = 2'b00;
  localparam logic [1:0] PARITY_ODD   = 2'b01;
  localparam logic [1:0] PARITY_EVEN  = 2'b10;
  localparam logic [1:0] PARITY_NONE1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } uart_state_e;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit generator shared by the transmit framer and the receive checker.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            parity_type,
  output logic                  parity_bit,
  output logic                  parity_en
);

  always_comb begin
    parity_en  = (parity_type == PARITY_ODD) || (parity_type == PARITY_EVEN);
    parity_bit = 1'b0;
    if (parity_type == PARITY_ODD) begin
      parity_bit = ~^data;
    end else if (parity_type == PARITY_EVEN) begin
      parity_bit = ^data;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one or two stop bits.
// Every line transition is taken on a baud_tick edge; tx comes straight from a flop.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output uart_state_e           state_dbg
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  gen_bit, gen_en;

  uart_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data        (data_in),
    .parity_type (parity_type),
    .parity_bit  (gen_bit),
    .parity_en   (gen_en)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // A tick coinciding with acceptance is deliberately not consumed here.
        if (send) begin
          shift_d    = data_in;
          par_bit_d  = gen_bit;
          par_en_d   = gen_en;
          two_stop_d = stop_bits;
          cnt_d      = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: if (baud_tick) begin
        state_d = ST_START;
        tx_d    = 1'b0;
      end
      ST_START: if (baud_tick) begin
        state_d = ST_DATA;
        tx_d    = shift_q[0];
        cnt_d   = '0;
      end
      ST_DATA: if (baud_tick) begin
        cnt_d   = cnt_q + 1'b1;
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP1;
          tx_d    = par_en_q ? par_bit_q : 1'b1;
        end else begin
          tx_d = shift_q[1];
        end
      end
      ST_PARITY: if (baud_tick) begin
        state_d = ST_STOP1;
        tx_d    = 1'b1;
      end
      ST_STOP1: if (baud_tick) begin
        tx_d = 1'b1;
        if (two_stop_q) begin
          state_d = ST_STOP2;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_STOP2: if (baud_tick) begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames from the test plan plus randomized loopback frames
// compared bit by bit against a line-level frame model.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          baud_tick = 1'b0;
  logic          send = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [1:0]    parity_type = 2'b00;
  logic          stop_bits = 1'b0;
  logic          tx, busy, done;
  uart_state_e   state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .baud_tick   (baud_tick),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the following falling edge.
  task automatic cycle(input logic tick);
    baud_tick = tick;
    @(posedge clock);
    @(negedge clock);
    baud_tick = 1'b0;
  endtask

  // Line model: the sequence of levels tx must show, one per tick, after acceptance.
  function automatic void build_frame(input logic [DW-1:0] d, input logic [1:0] pt, input logic sb);
    int ones;
    ones = $countones(d);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pt == 2'b01) exp_q.push_back(1'((ones % 2) == 0));
    if (pt == 2'b10) exp_q.push_back(1'((ones % 2) == 1));
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
  endfunction

  // Sends one frame starting at a falling edge where the DUT is idle (or in its done cycle)
  // and returns at the falling edge of the done cycle.
  task automatic run_frame(input logic [DW-1:0] d, input logic [1:0] pt, input logic sb,
                           input int gap_lo, input int gap_hi, input bit coincide, input bit poke);
    logic cur;
    int   gap, idx, poke_at;
    build_frame(d, pt, sb);
    send = 1'b1; data_in = d; parity_type = pt; stop_bits = sb;
    cycle(coincide);
    send = 1'b0;
    data_in = DW'($urandom); parity_type = 2'($urandom); stop_bits = 1'($urandom);
    check_eq("accept_busy", busy, 1);
    check_eq("accept_tx_idle", tx, 1);
    check_eq("accept_done_low", done, 0);
    cur = 1'b1;
    idx = 0;
    poke_at = $urandom_range(exp_q.size() - 1, 0);
    while (exp_q.size() > 0) begin
      gap = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gap; g++) begin
        send = poke && (idx == poke_at) && (g == 0);
        if (send) data_in = '0;
        cycle(1'b0);
        send = 1'b0;
        check_eq("hold_tx", tx, cur);
      end
      cycle(1'b1);
      cur = exp_q.pop_front();
      check_eq($sformatf("bit%0d_tx", idx), tx, cur);
      check_eq("bit_busy", busy, 1);
      check_eq("bit_done_low", done, 0);
      idx++;
    end
    gap = $urandom_range(gap_hi, gap_lo);
    repeat (gap) cycle(1'b0);
    cycle(1'b1);
    check_eq("end_done", done, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_tx", tx, 1);
  endtask

  initial begin
    logic [DW-1:0] d;
    bit chain;

    repeat (3) @(negedge clock);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_state", state_dbg, ST_IDLE);
    reset = 1'b0;
    cycle(1'b0);

    // directed frames
    run_frame(8'hA5, 2'b10, 1'b0, 3, 3, 1'b0, 1'b0);
    cycle(1'b0);
    check_eq("done_single_pulse", done, 0);
    run_frame(8'hA5, 2'b01, 1'b1, 1, 1, 1'b0, 1'b0);
    cycle(1'b0);
    run_frame(8'h01, 2'b11, 1'b0, 0, 0, 1'b1, 1'b0);
    cycle(1'b0);
    run_frame(8'h55, 2'b00, 1'b0, 1, 2, 1'b0, 1'b1);
    run_frame(8'hFF, 2'b10, 1'b1, 0, 1, 1'b0, 1'b0);
    cycle(1'b0);

    // reset during data bit 3
    send = 1'b1; data_in = 8'hA5; parity_type = 2'b10; stop_bits = 1'b0;
    cycle(1'b0);
    send = 1'b0;
    for (int t = 0; t < 5; t++) begin
      cycle(1'b0);
      cycle(1'b1);
    end
    check_eq("pre_reset_bit3", tx, 0);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_tx", tx, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_state", state_dbg, ST_IDLE);
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b0);
    run_frame(8'h3C, 2'b10, 1'b0, 1, 2, 1'b0, 1'b0);
    cycle(1'b0);

    // randomized frames over every parity setting
    for (int pt = 0; pt < 4; pt++) begin
      for (int k = 0; k < 256; k++) begin
        d = DW'($urandom);
        chain = 1'($urandom);
        run_frame(d, 2'(pt), 1'($urandom), 0, 2, 1'($urandom), 1'($urandom));
        if (!chain) begin
          cycle(1'b0);
          check_eq("rand_done_low", done, 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
